cam_read: RTL and testbench
===========================

CAM_READ -- requirements
Module: cam_read

Interface
REQ-001 Parameter: AW, 15, frame-buffer address width in bits.
REQ-002 Parameter: DW, 8, frame-buffer pixel width in bits (RGB332).
REQ-003 Parameter: IMG_W, 160, pixels per line.
REQ-004 Parameter: IMG_H, 120, lines per frame; IMG_W*IMG_H SHALL NOT exceed 2**AW.
REQ-005 Port: clk  input  1  camera pixel clock (PCLK); the single clock; all logic on its rising edge.
REQ-006 Port: rst  input  1  asynchronous, active-low reset.
REQ-007 Port: vsync  input  1  camera frame sync; high marks vertical blanking.
REQ-008 Port: href  input  1  camera line valid; high while pixel bytes are valid.
REQ-009 Port: px_data  input  8  camera byte bus, RGB565 byte stream, high byte first.
REQ-010 Port: mem_px_addr  output  AW  frame-buffer write address.
REQ-011 Port: mem_px_data  output  DW  frame-buffer write data (RGB332).
REQ-012 Port: px_wr  output  1  frame-buffer write enable; one-cycle pulse per pixel.
REQ-013 Port: frame_done  output  1  one-cycle pulse after the last pixel of a frame is written.

Function
REQ-014 The FSM SHALL have the states WAIT_VS, WAIT_FRAME, BYTE1, BYTE2, and SHALL leave reset in WAIT_VS.
REQ-015 WAIT_VS: on vsync=1, go to WAIT_FRAME; partial frames after reset are never captured.
REQ-016 WAIT_FRAME: clear the pixel counter to 0; on vsync=0, go to BYTE1.
REQ-017 BYTE1: on href=1, latch px_data as the high byte and go to BYTE2; on href=0, stay.
REQ-018 BYTE2: on href=1, form the pixel and go to BYTE1; on href=0, discard the latched byte and go to BYTE1, with no write.
REQ-019 Pixel conversion: mem_px_data = {hi[7:5], hi[2:0], lo[4:3]}, i.e. R3 = R5[4:2], G3 = G6[5:3], B2 = B5[4:3].
REQ-020 Write timing: on the edge that samples the low byte, register mem_px_data and mem_px_addr = counter, and drive px_wr=1 for exactly that following cycle.
REQ-021 The counter SHALL increment by 1 per write.
REQ-022 mem_px_addr and mem_px_data SHALL hold their last values while px_wr=0.
REQ-023 Bound: when counter = IMG_W*IMG_H, further pixels SHALL be dropped (px_wr stays 0) and the address SHALL never wrap.
REQ-024 frame_done SHALL pulse for one cycle in the cycle after the write with address IMG_W*IMG_H-1.
REQ-025 vsync=1 in BYTE1 or BYTE2: abort the pending pair and go to WAIT_FRAME; vsync overrides href in the same cycle.
REQ-026 Lines are not counted separately; the address is purely sequential within a frame.
REQ-027 Throughput: one pixel write per two clk cycles at most.

Reset
REQ-028 rst=0 SHALL immediately (asynchronously) force the state to WAIT_VS, the counter to 0, mem_px_addr=0, mem_px_data=0, px_wr=0, frame_done=0, and the latched byte to 0.
REQ-029 Reset asserted mid-frame SHALL discard the frame; capture resumes only after a full vsync high-to-low sequence.
REQ-030 Deassertion is taken synchronously by the first rising clk edge with rst=1.

Configuration
REQ-031 Macro CAM_TEST_PATTERN_EN: when defined, mem_px_data SHALL be replaced by eight vertical colour bars, computed from column = counter mod IMG_W, bar = column*8/IMG_W, bar colours in order 0xFF,0xFC,0x1F,0x1C,0xE3,0xE0,0x03,0x00; timing, addressing, px_wr and frame_done are unchanged and px_data is ignored.
REQ-032 Without CAM_TEST_PATTERN_EN, the bar logic SHALL be absent and the REQ-019 conversion is used.

Verification
REQ-033 Reset, vsync pulse, one line of href with bytes 0xF8,0x00 -> first write has addr 0, data 0xE0, px_wr high for 1 cycle.
REQ-034 Bytes 0x07,0xE0 then 0x00,0x1F -> data 0x1C at addr 0, then 0x03 at addr 1.
REQ-035 href drops after an odd byte count (3 bytes) -> exactly 1 write; the next line starts with addr 1.
REQ-036 Full 160x120 frame -> 19200 writes, last addr 19199, frame_done 1 cycle later; extra href bytes -> no writes.
REQ-037 vsync asserted at pixel 500, then a new frame -> next write addr 0; rst=0 mid-line -> all outputs 0 with no clk edge required.
REQ-038 With CAM_TEST_PATTERN_EN, one frame -> addr 0 data 0xFF, addr 20 data 0xFC, addr 159 data 0x00, addr 160 data 0xFF.

Source files
------------

// File: rtl/cam_read_if.sv
// Camera-side and frame-buffer-side signals of cam_read, bundled.
// master drives the camera pins; slave is the capture block.
interface cam_read_if #(
  parameter int AW = 15,
  parameter int DW = 8
);
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [AW-1:0] mem_px_addr;
  logic [DW-1:0] mem_px_data;
  logic          px_wr;
  logic          frame_done;

  modport master (
    output vsync, href, px_data,
    input  mem_px_addr, mem_px_data, px_wr, frame_done
  );

  modport slave (
    input  vsync, href, px_data,
    output mem_px_addr, mem_px_data, px_wr, frame_done
  );
endinterface

// File: rtl/cam_read.sv
// Captures an RGB565 camera byte stream into an RGB332 frame buffer, one write per pixel.
// Define CAM_TEST_PATTERN_EN to replace pixel data with eight vertical colour bars.
module cam_read #(
  parameter int AW    = 15,
  parameter int DW    = 8,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic       clk,
  input  logic       rst,
  cam_read_if.slave  bus
);
  localparam int TOTAL = IMG_W * IMG_H;
  // one extra bit so the counter can sit at TOTAL without wrapping
  localparam int CW    = AW + 1;

  typedef enum logic [1:0] {WAIT_VS, WAIT_FRAME, BYTE1, BYTE2} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    hi_q, hi_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          wr_q, wr_d;
  logic          done_q, done_d;
  logic [DW-1:0] pixel;

`ifdef CAM_TEST_PATTERN_EN
  localparam int COLW = $clog2(IMG_W + 1);
  logic [COLW-1:0] col_q, col_d;
  logic [2:0]      bar;

  assign bar = 3'((32'(col_q) * 8) / IMG_W);

  always_comb begin
    pixel = '0;
    case (bar)
      3'd0:    pixel = DW'(8'hFF);
      3'd1:    pixel = DW'(8'hFC);
      3'd2:    pixel = DW'(8'h1F);
      3'd3:    pixel = DW'(8'h1C);
      3'd4:    pixel = DW'(8'hE3);
      3'd5:    pixel = DW'(8'hE0);
      3'd6:    pixel = DW'(8'h03);
      default: pixel = DW'(8'h00);
    endcase
  end

  // column tracks counter mod IMG_W without a divider
  always_comb begin
    col_d = col_q;
    if (state_q == WAIT_FRAME) begin
      col_d = '0;
    end else if (wr_d) begin
      col_d = (32'(col_q) == IMG_W - 1) ? '0 : col_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
    end else begin
      col_q <= col_d;
    end
  end
`else
  // hi_q keeps only R5[4:2] and G6[5:3]; the low byte supplies B5[4:3]
  assign pixel = DW'({hi_q, bus.px_data[4:3]});
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    done_d  = wr_q && (addr_q == AW'(TOTAL - 1));
    case (state_q)
      WAIT_VS: begin
        if (bus.vsync) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        cnt_d = '0;
        if (!bus.vsync) state_d = BYTE1;
      end
      BYTE1: begin
        if (bus.vsync) begin
          state_d = WAIT_FRAME;
        end else if (bus.href) begin
          hi_d    = {bus.px_data[7:5], bus.px_data[2:0]};
          state_d = BYTE2;
        end
      end
      BYTE2: begin
        if (bus.vsync) begin
          state_d = WAIT_FRAME;
        end else begin
          state_d = BYTE1;
          if (bus.href && (cnt_q < CW'(TOTAL))) begin
            addr_d = cnt_q[AW-1:0];
            data_d = pixel;
            wr_d   = 1'b1;
            cnt_d  = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_VS;
      cnt_q   <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
    end
  end

  assign bus.mem_px_addr = addr_q;
  assign bus.mem_px_data = data_q;
  assign bus.px_wr       = wr_q;
  assign bus.frame_done  = done_q;
endmodule

// File: tb/tb_cam_read.sv
// Randomized bench for cam_read: a frame/line-level model predicts every write and frame_done pulse.
// Literal expectations pin the conversion, addressing, bounds and reset behaviour.
module tb_cam_read;
  localparam int AW    = 15;
  localparam int DW    = 8;
  localparam int IMG_W = 160;
  localparam int IMG_H = 120;
  localparam int TOTAL = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cam_read_if #(.AW(AW), .DW(DW)) bus ();

  cam_read #(.AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         cyc;
    int         addr;
    logic [7:0] data;
  } wr_t;

  wr_t        wq[$];
  int         dq[$];
  logic [7:0] lbytes[$];

  // model state: capture armed by a vsync high->low, pixel index within frame
  bit         cap_en = 1'b0;
  int         m_cnt  = 0;
  logic [7:0] m_hi   = '0;
  int         exp_addr_last = 0;
  logic [7:0] exp_data_last = '0;

  // observations from the DUT, used only for literal checks
  logic [7:0] obs [TOTAL];
  int         n_wr = 0;
  int         n_done = 0;
  int         last_addr = 0;
  logic [7:0] last_data = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  function automatic logic [7:0] expect_px(input logic [7:0] hi, input logic [7:0] lo, input int idx);
    logic [7:0] res;
`ifdef CAM_TEST_PATTERN_EN
    int bar;
    bar = ((idx % IMG_W) * 8) / IMG_W;
    case (bar)
      0: res = 8'hFF;
      1: res = 8'hFC;
      2: res = 8'h1F;
      3: res = 8'h1C;
      4: res = 8'hE3;
      5: res = 8'hE0;
      6: res = 8'h03;
      default: res = 8'h00;
    endcase
`else
    logic [4:0] r5;
    logic [5:0] g6;
    logic [4:0] b5;
    r5  = hi[7:3];
    g6  = {hi[2:0], lo[7:5]};
    b5  = lo[4:0];
    res = {r5[4:2], g6[5:3], b5[4:3]};
    if (idx < 0) res = 8'h00;
`endif
    return res;
  endfunction

  task automatic cyc(input bit vs, input bit hr, input logic [7:0] d);
    bus.vsync   = vs;
    bus.href    = hr;
    bus.px_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 8'($urandom));
  endtask

  // i = byte index within the current href run, exp_cyc = cycle the write must appear
  task automatic model_byte(input int i, input logic [7:0] b, input int exp_cyc);
    wr_t w;
    if (i % 2 == 0) begin
      m_hi = b;
    end else if (cap_en && m_cnt < TOTAL) begin
      w.cyc  = exp_cyc;
      w.addr = m_cnt;
      w.data = expect_px(m_hi, b, m_cnt);
      wq.push_back(w);
      if (m_cnt == TOTAL - 1) dq.push_back(exp_cyc + 1);
      m_cnt++;
    end
  endtask

  task automatic do_vsync();
    repeat (1 + $urandom_range(0, 3)) cyc(1'b1, 1'b0, 8'($urandom));
    cap_en = 1'b1;
    m_cnt  = 0;
    repeat (2) cyc(1'b0, 1'b0, 8'($urandom));
  endtask

  task automatic send_q();
    for (int i = 0; i < lbytes.size(); i++) begin
      model_byte(i, lbytes[i], cyc_n + 1);
      cyc(1'b0, 1'b1, lbytes[i]);
    end
    lbytes.delete();
    idle(2 + $urandom_range(0, 3));
  endtask

  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) lbytes.push_back(8'($urandom));
    send_q();
  endtask

  task automatic send_abort(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      model_byte(i, b, cyc_n + 1);
      cyc(1'b0, 1'b1, b);
    end
    cyc(1'b1, 1'b1, 8'($urandom));
  endtask

  task automatic reset_mid();
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_px_wr", bus.px_wr, 0);
    chk("async_rst_frame_done", bus.frame_done, 0);
    chk("async_rst_addr", bus.mem_px_addr, 0);
    chk("async_rst_data", bus.mem_px_data, 0);
    wq.delete();
    dq.delete();
    cap_en = 1'b0;
    m_cnt = 0;
    exp_addr_last = 0;
    exp_data_last = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  always @(negedge clk) begin : cmp
    bit  exp_wr;
    bit  exp_done;
    wr_t w;
    if (rst) begin
      exp_wr = (wq.size() > 0) && (wq[0].cyc == cyc_n);
      chk("px_wr", bus.px_wr, exp_wr);
      if (exp_wr) begin
        w = wq.pop_front();
        chk("mem_px_addr", bus.mem_px_addr, w.addr);
        chk("mem_px_data", bus.mem_px_data, w.data);
        exp_addr_last = w.addr;
        exp_data_last = w.data;
      end else begin
        chk("addr_hold", bus.mem_px_addr, exp_addr_last);
        chk("data_hold", bus.mem_px_data, exp_data_last);
      end
      exp_done = (dq.size() > 0) && (dq[0] == cyc_n);
      if (exp_done) void'(dq.pop_front());
      chk("frame_done", bus.frame_done, exp_done);
      if (bus.px_wr === 1'b1) begin
        n_wr++;
        last_addr = int'(bus.mem_px_addr);
        last_data = bus.mem_px_data;
        if (last_addr < TOTAL) obs[last_addr] = last_data;
      end
      if (bus.frame_done === 1'b1) n_done++;
    end
  end

  initial begin
    int w0;
    int d0;
    bus.vsync   = 1'b0;
    bus.href    = 1'b0;
    bus.px_data = 8'h00;

    #2;
    rst = 1'b0;
    #1;
    chk("reset_px_wr", bus.px_wr, 0);
    chk("reset_frame_done", bus.frame_done, 0);
    chk("reset_addr", bus.mem_px_addr, 0);
    chk("reset_data", bus.mem_px_data, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;

    send_rand(6);
    chk("no_capture_before_vsync", n_wr, 0);
    $display("scenario pre-vsync line: writes=%0d", n_wr);

    do_vsync();
    lbytes = '{8'hF8, 8'h00};
    send_q();
    chk("first_write_count", n_wr, 1);
    chk("first_write_addr", last_addr, 0);
`ifndef CAM_TEST_PATTERN_EN
    chk("first_write_data", last_data, 8'hE0);
`endif
    $display("scenario first pixel: addr=%0d data=0x%02h", last_addr, last_data);

    do_vsync();
    lbytes = '{8'h07, 8'hE0, 8'h00, 8'h1F};
    send_q();
`ifndef CAM_TEST_PATTERN_EN
    chk("green_pixel", obs[0], 8'h1C);
    chk("blue_pixel", obs[1], 8'h03);
`endif
    chk("two_pixel_last_addr", last_addr, 1);
    $display("scenario two pixels: data0=0x%02h data1=0x%02h", obs[0], obs[1]);

    do_vsync();
    w0 = n_wr;
    send_rand(3);
    chk("odd_line_writes", n_wr - w0, 1);
    send_rand(2);
    chk("next_line_addr", last_addr, 1);
    $display("scenario odd byte line: last_addr=%0d", last_addr);

    do_vsync();
    for (int l = 0; l < 40; l++) begin
      if ($urandom_range(0, 7) == 0) do_vsync();
      send_rand($urandom_range(0, 41));
    end
    $display("scenario random lines: total writes=%0d", n_wr);

    do_vsync();
    send_abort(1000);
    chk("abort_last_addr", last_addr, 499);
    do_vsync();
    lbytes = '{8'hF8, 8'h00};
    send_q();
    chk("after_abort_addr", last_addr, 0);
    $display("scenario vsync abort: restart addr=%0d", last_addr);

    do_vsync();
    w0 = n_wr;
    d0 = n_done;
    for (int l = 0; l < IMG_H; l++) send_rand(2 * IMG_W);
    chk("frame_writes", n_wr - w0, TOTAL);
    chk("frame_last_addr", last_addr, TOTAL - 1);
    chk("frame_done_count", n_done - d0, 1);
    send_rand(20);
    chk("overflow_writes", n_wr - w0, TOTAL);
    chk("overflow_addr_hold", bus.mem_px_addr, TOTAL - 1);
`ifdef CAM_TEST_PATTERN_EN
    chk("bar_addr0", obs[0], 8'hFF);
    chk("bar_addr20", obs[20], 8'hFC);
    chk("bar_addr159", obs[159], 8'h00);
    chk("bar_addr160", obs[160], 8'hFF);
`endif
    $display("scenario full frame: writes=%0d last_addr=%0d", n_wr - w0, last_addr);

    do_vsync();
    for (int i = 0; i < 7; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      model_byte(i, b, cyc_n + 1);
      cyc(1'b0, 1'b1, b);
    end
    reset_mid();
    w0 = n_wr;
    send_rand(4);
    chk("no_capture_after_reset", n_wr - w0, 0);
    do_vsync();
    lbytes = '{8'hF8, 8'h00};
    send_q();
    chk("after_reset_addr", last_addr, 0);
    chk("after_reset_writes", n_wr - w0, 1);
    $display("scenario mid-line reset: restart addr=%0d", last_addr);

    idle(5);
    chk("write_queue_drained", wq.size(), 0);
    chk("done_queue_drained", dq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
